// File: rtl/msf_frame_decoder.sv
// MSF minute-frame decoder: captures the per-second (A,B) bits of one minute,
// validates the frame at the next minute marker and emits a BCD time load.
module msf_frame_decoder #(
   parameter int unsigned MISS_LIMIT = 3
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       minute_marker_i,
   input  logic       bit_valid_i,
   input  logic       bit_a_i,
   input  logic       bit_b_i,
   output logic       load_o,
   output logic [1:0] load_hour_msd_o,
   output logic [3:0] load_hour_lsd_o,
   output logic [2:0] load_min_msd_o,
   output logic [3:0] load_min_lsd_o,
   output logic [2:0] load_sec_msd_o,
   output logic [3:0] load_sec_lsd_o,
   output logic       frame_err_o,
   output logic       synced_o
);

   logic [5:0] idx;
   logic       armed;
   logic [1:0] hr_t;
   logic [3:0] hr_u;
   logic [2:0] mn_t;
   logic [3:0] mn_u;
   logic [7:0] ident;
   logic       par;
   logic [3:0] miss;

   logic [6:0] sec;
   logic [3:0] miss_next;
   logic       good;

   // Seconds are always loaded as 00.
   assign load_sec_msd_o = '0;
   assign load_sec_lsd_o = '0;

   // Second number of the incoming strobe; 7 bits so idx==63 cannot wrap.
   assign sec = {1'b0, idx} + 7'd1;

   // Frame acceptance test and saturating miss counter increment.
   always_comb begin
      good = (idx == 6'd59) && (ident == 8'b0111_1110) && par &&
             (hr_t <= 2'd2) && (hr_u <= 4'd9) &&
             ((hr_t < 2'd2) || (hr_u <= 4'd3)) &&
             (mn_t <= 3'd5) && (mn_u <= 4'd9);
      miss_next = (miss == 4'd15) ? miss : miss + 4'd1;
   end

   // Bit capture, marker-time frame evaluation and registered outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         idx             <= '0;
         armed           <= 1'b0;
         hr_t            <= '0;
         hr_u            <= '0;
         mn_t            <= '0;
         mn_u            <= '0;
         ident           <= '0;
         par             <= 1'b0;
         miss            <= '0;
         load_o          <= 1'b0;
         frame_err_o     <= 1'b0;
         synced_o        <= 1'b0;
         load_hour_msd_o <= '0;
         load_hour_lsd_o <= '0;
         load_min_msd_o  <= '0;
         load_min_lsd_o  <= '0;
      end else begin
         load_o      <= 1'b0;
         frame_err_o <= 1'b0;
         if (minute_marker_i) begin
            if (!armed) begin
               armed <= 1'b1;
               hr_t  <= '0;
               hr_u  <= '0;
               mn_t  <= '0;
               mn_u  <= '0;
            end else if (good) begin
               load_o          <= 1'b1;
               load_hour_msd_o <= hr_t;
               load_hour_lsd_o <= hr_u;
               load_min_msd_o  <= mn_t;
               load_min_lsd_o  <= mn_u;
               miss            <= '0;
               synced_o        <= 1'b1;
            end else begin
               frame_err_o <= 1'b1;
               miss        <= miss_next;
               if (32'(miss_next) >= MISS_LIMIT)
                  synced_o <= 1'b0;
            end
            idx   <= '0;
            par   <= 1'b0;
            ident <= '0;
         end else if (bit_valid_i && (idx != 6'd63)) begin
            idx <= idx + 6'd1;
            if (sec >= 7'd39 && sec <= 7'd40) hr_t <= {hr_t[0], bit_a_i};
            if (sec >= 7'd41 && sec <= 7'd44) hr_u <= {hr_u[2:0], bit_a_i};
            if (sec >= 7'd45 && sec <= 7'd47) mn_t <= {mn_t[1:0], bit_a_i};
            if (sec >= 7'd48 && sec <= 7'd51) mn_u <= {mn_u[2:0], bit_a_i};
            if (sec >= 7'd52 && sec <= 7'd59) ident <= {ident[6:0], bit_a_i};
            // A39..51 and B57 never fall on the same strobe, so one update suffices.
            if (sec >= 7'd39 && sec <= 7'd51) par <= par ^ bit_a_i;
            else if (sec == 7'd57)            par <= par ^ bit_b_i;
         end
      end
   end

endmodule

// File: tb/tb_msf_frame_decoder.sv
// Self-checking bench for msf_frame_decoder with a frame-level reference model.
module tb_msf_frame_decoder;

   logic       clk = 1'b0;
   logic       rst_i = 1'b1;
   logic       minute_marker_i = 1'b0;
   logic       bit_valid_i = 1'b0;
   logic       bit_a_i = 1'b0;
   logic       bit_b_i = 1'b0;
   logic       load_o;
   logic [1:0] load_hour_msd_o;
   logic [3:0] load_hour_lsd_o;
   logic [2:0] load_min_msd_o;
   logic [3:0] load_min_lsd_o;
   logic [2:0] load_sec_msd_o;
   logic [3:0] load_sec_lsd_o;
   logic       frame_err_o;
   logic       synced_o;

   int checks = 0;
   int errors = 0;

   // reference model state
   bit  m_armed, m_synced;
   int  m_miss;
   int  m_ht, m_hu, m_mt, m_mu;
   bit  q_a[$];
   bit  q_b[$];

   // frame under construction, indexed by second 1..70
   bit  fa[1:70];
   bit  fb[1:70];

   msf_frame_decoder #(.MISS_LIMIT(3)) dut (
      .clk_i(clk), .rst_i(rst_i), .minute_marker_i(minute_marker_i),
      .bit_valid_i(bit_valid_i), .bit_a_i(bit_a_i), .bit_b_i(bit_b_i),
      .load_o(load_o), .load_hour_msd_o(load_hour_msd_o),
      .load_hour_lsd_o(load_hour_lsd_o), .load_min_msd_o(load_min_msd_o),
      .load_min_lsd_o(load_min_lsd_o), .load_sec_msd_o(load_sec_msd_o),
      .load_sec_lsd_o(load_sec_lsd_o), .frame_err_o(frame_err_o),
      .synced_o(synced_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // value of A bits s_lo..s_hi of the captured frame, MSB first
   function automatic int field(input int lo, input int hi);
      int v = 0;
      for (int s = lo; s <= hi; s++) v = v * 2 + int'(q_a[s-1]);
      return v;
   endfunction

   task automatic check_outputs(input bit exp_load, input bit exp_err);
      chk("load", {7'b0, load_o}, {7'b0, exp_load});
      chk("frame_err", {7'b0, frame_err_o}, {7'b0, exp_err});
      chk("synced", {7'b0, synced_o}, {7'b0, m_synced});
      chk("hour_msd", {6'b0, load_hour_msd_o}, 8'(m_ht));
      chk("hour_lsd", {4'b0, load_hour_lsd_o}, 8'(m_hu));
      chk("min_msd", {5'b0, load_min_msd_o}, 8'(m_mt));
      chk("min_lsd", {4'b0, load_min_lsd_o}, 8'(m_mu));
      chk("sec_msd", {5'b0, load_sec_msd_o}, 8'd0);
      chk("sec_lsd", {4'b0, load_sec_lsd_o}, 8'd0);
   endtask

   // one clock with the given strobes, then model update and output check
   task automatic cycle(input bit mk, input bit bv, input bit a, input bit b);
      bit exp_load = 0, exp_err = 0, good;
      int ident, p, ht, hu, mt, mu;
      minute_marker_i = mk; bit_valid_i = bv; bit_a_i = a; bit_b_i = b;
      @(posedge clk); #1;
      minute_marker_i = 0; bit_valid_i = 0;
      if (mk) begin
         if (!m_armed) begin
            m_armed = 1;
         end else begin
            good = (q_a.size() == 59);
            if (good) begin
               ident = field(52, 59);
               p = int'(q_b[56]);
               for (int s = 39; s <= 51; s++) p ^= int'(q_a[s-1]);
               ht = field(39, 40); hu = field(41, 44);
               mt = field(45, 47); mu = field(48, 51);
               good = (ident == 8'h7E) && (p == 1) && (ht <= 2) && (hu <= 9) &&
                      (ht * 10 + hu <= 23) && (mt <= 5) && (mu <= 9);
            end
            if (good) begin
               exp_load = 1;
               m_ht = ht; m_hu = hu; m_mt = mt; m_mu = mu;
               m_miss = 0; m_synced = 1;
            end else begin
               exp_err = 1;
               if (m_miss < 15) m_miss++;
               if (m_miss >= 3) m_synced = 0;
            end
         end
         q_a.delete(); q_b.delete();
      end else if (bv) begin
         q_a.push_back(a); q_b.push_back(b);
      end
      check_outputs(exp_load, exp_err);
   endtask

   task automatic do_reset();
      rst_i = 1;
      m_armed = 0; m_synced = 0; m_miss = 0;
      m_ht = 0; m_hu = 0; m_mt = 0; m_mu = 0;
      q_a.delete(); q_b.delete();
      cycle(0, 0, 0, 0);
      cycle(0, 1, 1, 1);
      q_a.delete(); q_b.delete();
      rst_i = 0;
   endtask

   // fill fa/fb with a frame announcing ht hu : mt mu
   task automatic build(input int ht, input int hu, input int mt, input int mu,
                        input bit bad_par, input bit bad_ident);
      bit [12:0] t;
      bit [7:0]  id;
      for (int s = 1; s <= 70; s++) begin
         fa[s] = 1'($urandom); fb[s] = 1'($urandom);
      end
      t = {2'(ht), 4'(hu), 3'(mt), 4'(mu)};
      for (int k = 0; k < 13; k++) fa[39+k] = t[12-k];
      id = bad_ident ? 8'b0111_1100 : 8'b0111_1110;
      for (int k = 0; k < 8; k++) fa[52+k] = id[7-k];
      fb[57] = 1'b1 ^ (^t) ^ bad_par;
   endtask

   // seconds 1..n with random idle gaps, then the closing marker
   task automatic send(input int n);
      for (int s = 1; s <= n; s++) begin
         repeat ($urandom_range(0, 1)) cycle(0, 0, 1'($urandom), 1'($urandom));
         cycle(0, 1, fa[s], fb[s]);
      end
      cycle(1, 1'($urandom), 1'($urandom), 1'($urandom));
   endtask

   initial begin
      do_reset();
      // first marker only arms
      cycle(1, 0, 0, 0);
      // 13:47 good frame
      build(1, 3, 4, 7, 0, 0); send(59);
      // bad parity
      build(1, 3, 4, 7, 1, 0); send(59);
      // 58, 60 and overlong frames
      build(0, 9, 2, 1, 0, 0); send(58);
      build(0, 9, 2, 1, 0, 0); send(60);
      build(0, 9, 2, 1, 0, 0); send(68);
      // hour 24 rejected, 23:59 accepted
      build(2, 4, 0, 0, 0, 0); send(59);
      build(2, 3, 5, 9, 0, 0); send(59);
      // three bad frames drop sync, one good restores
      build(1, 0, 1, 0, 0, 1); send(59);
      build(1, 0, 1, 0, 1, 0); send(59);
      build(1, 0, 6, 0, 0, 0); send(59);
      build(0, 5, 3, 0, 0, 0); send(59);
      // reset mid-frame then re-arm
      build(1, 1, 1, 1, 0, 0);
      for (int s = 1; s <= 20; s++) cycle(0, 1, fa[s], fb[s]);
      do_reset();
      for (int s = 21; s <= 40; s++) cycle(0, 1, fa[s], fb[s]);
      cycle(1, 0, 0, 0);
      build(1, 2, 3, 4, 0, 0); send(59);
      // randomized frames
      for (int i = 0; i < 14; i++) begin
         int r = $urandom_range(0, 9);
         build($urandom_range(0, 2), $urandom_range(0, 11), $urandom_range(0, 6),
               $urandom_range(0, 10), ($urandom_range(0, 5) == 0),
               ($urandom_range(0, 7) == 0));
         send(r == 0 ? 58 : (r == 1 ? 60 : 59));
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
